// File: rtl/wordle_guess_eval_pkg.sv
// Shared definitions for the Wordle guess scorer: sizes, colour codes,
// FSM state encoding and a letter extraction helper.
package wordle_guess_eval_pkg;

    localparam int WORD_LEN = 5;
    localparam int NUM_ROWS = 6;

    localparam logic [2:0] LAST_ROW = 3'(NUM_ROWS - 1);
    localparam logic [2:0] LAST_IDX = 3'(WORD_LEN - 1);

    typedef logic [1:0] colour_t;

    localparam colour_t COL_EMPTY  = 2'b00;
    localparam colour_t COL_GRAY   = 2'b01;
    localparam colour_t COL_YELLOW = 2'b10;
    localparam colour_t COL_GREEN  = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_GREEN  = 3'd1,
        ST_YELLOW = 3'd2,
        ST_WRITE  = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    // Letter 0 sits in the most significant byte of the packed word.
    function automatic logic [7:0] letter_at(input logic [8*WORD_LEN-1:0] word,
                                             input logic [2:0]            idx);
        int pos;
        pos = WORD_LEN - 1 - int'(idx);
        return word[8*pos +: 8];
    endfunction

endpackage

// File: rtl/wordle_guess_eval_letter_match.sv
// Finds the lowest still-unused answer position holding a given guess letter.
module wordle_guess_eval_letter_match
    import wordle_guess_eval_pkg::*;
(
    input  logic [7:0]            i_letter,
    input  logic [8*WORD_LEN-1:0] i_word,
    input  logic [WORD_LEN-1:0]   i_used,
    output logic                  o_hit,
    output logic [2:0]            o_idx
);

    // Scan from the top down so the last assignment wins with the lowest index.
    always_comb begin
        o_hit = 1'b0;
        o_idx = 3'd0;
        for (int j = WORD_LEN - 1; j >= 0; j--) begin
            if (!i_used[j] && (letter_at(i_word, 3'(j)) == i_letter)) begin
                o_hit = 1'b1;
                o_idx = 3'(j);
            end
        end
    end

endmodule

// File: rtl/wordle_guess_eval.sv
// Scores a guess against the answer (greens first, then yellows consuming
// unused answer positions left to right) and keeps a per-row colour table
// for the renderer.
module wordle_guess_eval
    import wordle_guess_eval_pkg::*;
(
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_clear,
    input  logic                  i_start,
    input  logic [8*WORD_LEN-1:0] i_guess,
    input  logic [8*WORD_LEN-1:0] i_answer,
    input  logic [2:0]            i_row,
    output logic                  o_busy,
    output logic                  o_done,
    output logic [2*WORD_LEN-1:0] o_colors,
    output logic                  o_win,
    input  logic [2:0]            i_rd_row,
    output logic [2*WORD_LEN-1:0] o_rd_colors
);

    state_t                r_state;
    state_t                w_next;
    logic [2:0]            r_idx;
    logic [WORD_LEN-1:0]   r_used;
    colour_t               r_col [WORD_LEN];
    logic [8*WORD_LEN-1:0] r_guess;
    logic [8*WORD_LEN-1:0] r_answer;
    logic [2:0]            r_row;
    logic [2*WORD_LEN-1:0] r_colors;
    logic                  r_win;
    logic [2*WORD_LEN-1:0] r_table [NUM_ROWS];

    logic [7:0]            w_g_letter;
    logic [7:0]            w_a_letter;
    logic                  w_hit;
    logic [2:0]            w_hit_idx;
    logic [2*WORD_LEN-1:0] w_col_packed;

    assign w_g_letter   = letter_at(r_guess, r_idx);
    assign w_a_letter   = letter_at(r_answer, r_idx);
    assign w_col_packed = {r_col[0], r_col[1], r_col[2], r_col[3], r_col[4]};

    wordle_guess_eval_letter_match u_match (
        .i_letter (w_g_letter),
        .i_word   (r_answer),
        .i_used   (r_used),
        .o_hit    (w_hit),
        .o_idx    (w_hit_idx)
    );

    // State register.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) r_state <= ST_IDLE;
        else         r_state <= w_next;
    end

    // Next-state logic: five GREEN and five YELLOW passes, one WRITE, one DONE.
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:   if (i_start) w_next = ST_GREEN;
            ST_GREEN:  if (r_idx == LAST_IDX) w_next = ST_YELLOW;
            ST_YELLOW: if (r_idx == LAST_IDX) w_next = ST_WRITE;
            ST_WRITE:  w_next = ST_DONE;
            ST_DONE:   w_next = ST_IDLE;
            default:   w_next = ST_IDLE;
        endcase
    end

    // Status outputs decoded from the state.
    always_comb begin
        o_busy = (r_state != ST_IDLE);
        o_done = (r_state == ST_DONE);
    end

    // Operand latch, letter index, used mask and working colours.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_idx    <= 3'd0;
            r_used   <= '0;
            r_guess  <= '0;
            r_answer <= '0;
            r_row    <= 3'd0;
            r_colors <= '0;
            r_win    <= 1'b0;
            for (int k = 0; k < WORD_LEN; k++) r_col[k] <= COL_EMPTY;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_start) begin
                        r_guess  <= i_guess;
                        r_answer <= i_answer;
                        r_row    <= i_row;
                        r_idx    <= 3'd0;
                        r_used   <= '0;
                        r_colors <= '0;
                        r_win    <= 1'b0;
                        for (int k = 0; k < WORD_LEN; k++) r_col[k] <= COL_EMPTY;
                    end
                end
                ST_GREEN: begin
                    if (w_g_letter == w_a_letter) begin
                        r_col[r_idx]  <= COL_GREEN;
                        r_used[r_idx] <= 1'b1;
                    end
                    r_idx <= (r_idx == LAST_IDX) ? 3'd0 : r_idx + 3'd1;
                end
                ST_YELLOW: begin
                    if (r_col[r_idx] != COL_GREEN) begin
                        if (w_hit) begin
                            r_col[r_idx]      <= COL_YELLOW;
                            r_used[w_hit_idx] <= 1'b1;
                        end else begin
                            r_col[r_idx] <= COL_GRAY;
                        end
                    end
                    r_idx <= (r_idx == LAST_IDX) ? 3'd0 : r_idx + 3'd1;
                end
                ST_WRITE: begin
                    // Loaded here so the result is already visible during DONE.
                    r_colors <= w_col_packed;
                    r_win    <= (w_col_packed == {WORD_LEN{COL_GREEN}});
                end
                default: ;
            endcase
        end
    end

    // Colour table: clear wins over a same-cycle write; rows above 5 are dropped.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            for (int k = 0; k < NUM_ROWS; k++) r_table[k] <= '0;
        end else if (i_clear) begin
            for (int k = 0; k < NUM_ROWS; k++) r_table[k] <= '0;
        end else if ((r_state == ST_WRITE) && (r_row <= LAST_ROW)) begin
            r_table[r_row] <= w_col_packed;
        end
    end

    // Renderer read port.
    always_comb begin
        o_rd_colors = '0;
        if (i_rd_row <= LAST_ROW) o_rd_colors = r_table[i_rd_row];
    end

    assign o_colors = r_colors;
    assign o_win    = r_win;

endmodule

// File: tb/tb_wordle_guess_eval.sv
// Randomized self-checking bench for wordle_guess_eval with a letter-count
// reference model and a shadow copy of the colour table.
module tb_wordle_guess_eval;

    logic        clk = 1'b0;
    logic        i_reset, i_clear, i_start;
    logic [39:0] i_guess, i_answer;
    logic [2:0]  i_row, i_rd_row;
    logic        o_busy, o_done, o_win;
    logic [9:0]  o_colors, o_rd_colors;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [9:0]  tbl [6];

    always #5 clk = ~clk;

    wordle_guess_eval dut (
        .i_clk       (clk),
        .i_reset     (i_reset),
        .i_clear     (i_clear),
        .i_start     (i_start),
        .i_guess     (i_guess),
        .i_answer    (i_answer),
        .i_row       (i_row),
        .o_busy      (o_busy),
        .o_done      (o_done),
        .o_colors    (o_colors),
        .o_win       (o_win),
        .i_rd_row    (i_rd_row),
        .o_rd_colors (o_rd_colors)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Wordle scoring by letter counts: greens first, remaining answer letters
    // are then handed out as yellows left to right.
    function automatic logic [9:0] ref_score(input logic [39:0] g, input logic [39:0] a);
        byte unsigned gl [5];
        byte unsigned al [5];
        int           left [256];
        logic [1:0]   c [5];
        logic [9:0]   res;
        foreach (left[k]) left[k] = 0;
        for (int i = 0; i < 5; i++) begin
            gl[i] = g[39-8*i -: 8];
            al[i] = a[39-8*i -: 8];
        end
        for (int i = 0; i < 5; i++) begin
            if (gl[i] == al[i]) c[i] = 2'b11;
            else begin
                c[i] = 2'b01;
                left[al[i]]++;
            end
        end
        for (int i = 0; i < 5; i++) begin
            if (c[i] != 2'b11 && left[gl[i]] > 0) begin
                c[i] = 2'b10;
                left[gl[i]]--;
            end
        end
        res = {c[0], c[1], c[2], c[3], c[4]};
        return res;
    endfunction

    function automatic logic [39:0] rand_word(input int alpha);
        logic [39:0] w;
        for (int i = 0; i < 5; i++) begin
            if ($urandom_range(0, 15) == 0) w[39-8*i -: 8] = 8'h20;
            else w[39-8*i -: 8] = 8'(8'h41 + $urandom_range(0, alpha - 1));
        end
        return w;
    endfunction

    // Cycle 0 carries the start pulse; done must appear in cycle 12 exactly once.
    // dup_cyc re-pulses start (different operands) mid-run, clr_cyc pulses clear.
    task automatic run_score(input logic [39:0] g, input logic [39:0] a, input logic [2:0] r,
                             input int dup_cyc, input int clr_cyc,
                             output logic [9:0] col, output logic w);
        int lat;
        int ndone;
        @(negedge clk);
        i_guess  = g;
        i_answer = a;
        i_row    = r;
        i_start  = 1'b1;
        lat = -1; ndone = 0; col = '0; w = 1'b0;
        for (int c = 1; c <= 16; c++) begin
            @(negedge clk);
            if (o_done) begin
                ndone++;
                if (lat < 0) begin
                    lat = c;
                    col = o_colors;
                    w   = o_win;
                end
            end
            if (c == 12) chk("busy_in_done", o_busy, 1);
            if (c == 13) chk("busy_after_done", o_busy, 0);
            i_start = (c == dup_cyc);
            if (c == dup_cyc) begin
                i_guess = ~g;
                i_row   = r ^ 3'd1;
            end
            i_clear = (c == clr_cyc);
        end
        i_start = 1'b0;
        i_clear = 1'b0;
        chk("latency", lat, 12);
        chk("done_pulses", ndone, 1);
    endtask

    task automatic check_table(input string tag);
        for (int r = 0; r < 8; r++) begin
            @(negedge clk);
            i_rd_row = 3'(r);
            #1;
            chk($sformatf("%s_row%0d", tag, r), o_rd_colors, (r < 6) ? tbl[r] : 10'd0);
        end
    endtask

    task automatic score_and_track(input logic [39:0] g, input logic [39:0] a,
                                   input logic [2:0] r, input string tag);
        logic [9:0] col, exp;
        logic       w;
        exp = ref_score(g, a);
        run_score(g, a, r, -1, -1, col, w);
        chk({tag, "_colors"}, col, exp);
        chk({tag, "_win"}, w, exp == 10'h3FF);
        if (r < 3'd6) tbl[r] = exp;
    endtask

    initial begin
        logic [9:0]  col;
        logic        w;
        logic [39:0] g, a;
        logic [2:0]  r;
        int          cnt;

        i_reset = 1'b1; i_clear = 1'b0; i_start = 1'b0;
        i_guess = '0; i_answer = '0; i_row = '0; i_rd_row = '0;
        foreach (tbl[k]) tbl[k] = '0;
        repeat (2) @(negedge clk);
        chk("rst_busy", o_busy, 0);
        chk("rst_done", o_done, 0);
        chk("rst_colors", o_colors, 0);
        chk("rst_win", o_win, 0);
        i_reset = 1'b0;
        check_table("reset");

        // Exact match.
        run_score("CRANE", "CRANE", 3'd0, -1, -1, col, w);
        chk("crane_colors", col, 10'h3FF);
        chk("crane_win", w, 1);
        tbl[0] = 10'h3FF;
        repeat (3) @(negedge clk);
        chk("crane_held_colors", o_colors, 10'h3FF);
        chk("crane_held_win", o_win, 1);

        // EERIE/THERE: only E4 green; E0 takes the spare E, R takes the R,
        // E1 finds no E left -> yellow,gray,yellow,gray,green.
        run_score("EERIE", "THERE", 3'd1, -1, -1, col, w);
        chk("eerie_colors", col, 10'h267);
        chk("eerie_model", col, ref_score("EERIE", "THERE"));
        chk("eerie_win", w, 0);
        tbl[1] = 10'h267;

        // SPEED/ABIDE: S,P gray; first E yellow; second E gray; D yellow.
        run_score("SPEED", "ABIDE", 3'd2, -1, -1, col, w);
        chk("speed_colors", col, 10'h166);
        chk("speed_win", w, 0);
        tbl[2] = 10'h166;

        // Start while busy is ignored; would otherwise hit row 2 with other operands.
        run_score("PLANT", "SLANT", 3'd3, 5, -1, col, w);
        chk("busy_start_colors", col, ref_score("PLANT", "SLANT"));
        tbl[3] = ref_score("PLANT", "SLANT");
        check_table("first4");

        score_and_track(rand_word(4), rand_word(4), 3'd4, "r4");
        score_and_track(rand_word(4), rand_word(4), 3'd5, "r5");
        check_table("full");

        @(negedge clk); i_clear = 1'b1;
        @(negedge clk); i_clear = 1'b0;
        foreach (tbl[k]) tbl[k] = '0;
        check_table("clear");

        // Out-of-range row: scoring completes, nothing is written.
        score_and_track("ABBEY", "BABES", 3'd7, "row7");
        check_table("row7");

        // Clear coinciding with WRITE wins; clear earlier in the run does not abort it.
        g = rand_word(3); a = rand_word(3);
        run_score(g, a, 3'd0, -1, 11, col, w);
        chk("clr_write_colors", col, ref_score(g, a));
        run_score(g, a, 3'd1, -1, 3, col, w);
        chk("clr_early_colors", col, ref_score(g, a));
        tbl[1] = ref_score(g, a);
        check_table("clr_prio");

        // Reset in the middle of scoring.
        score_and_track(rand_word(5), rand_word(5), 3'd4, "pre_rst");
        @(negedge clk);
        i_guess = "HELLO"; i_answer = "WORLD"; i_row = 3'd5; i_start = 1'b1;
        for (int c = 1; c <= 7; c++) begin
            @(negedge clk);
            i_start = 1'b0;
            if (c == 7) i_reset = 1'b1;
        end
        @(negedge clk);
        chk("midrst_busy", o_busy, 0);
        chk("midrst_done", o_done, 0);
        chk("midrst_colors", o_colors, 0);
        chk("midrst_win", o_win, 0);
        i_reset = 1'b0;
        cnt = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (o_done || o_busy) cnt++;
        end
        chk("midrst_quiet", cnt, 0);
        foreach (tbl[k]) tbl[k] = '0;
        check_table("midrst");
        score_and_track("HELLO", "WORLD", 3'd5, "post_rst");

        // Random words from small alphabets to force duplicate letters.
        for (int n = 0; n < 30; n++) begin
            g = rand_word($urandom_range(2, 6));
            a = ($urandom_range(0, 4) == 0) ? g : rand_word($urandom_range(2, 6));
            r = 3'($urandom_range(0, 7));
            score_and_track(g, a, r, $sformatf("rnd%0d", n));
        end
        check_table("random");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
